im_loader: RTL and testbench

- Writer side of the instruction memory: receives a byte-stream program image, assembles 9-bit instructions and writes them into the instruction memory at consecutive addresses from 0.
- Holds the CPU (PC/regs) in hold while loading; releases it only after a frame passes its checksum.
- Sits between a byte source (host link or bench driver) and the computer's instruction memory write port.
- Replaces $readmemb preloading in synthesizable builds.

---
 rtl/im_loader_pkg.sv | 17 +
 rtl/im_loader_csum.sv | 25 ++
 rtl/im_loader.sv | 149 ++++++++++++++
 tb/tb_im_loader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and the default frame start marker.
package im_loader_pkg;

    typedef enum logic [2:0] {
        StSync = 3'd0,
        StLen  = 3'd1,
        StLo   = 3'd2,
        StHi   = 3'd3,
        StCsum = 3'd4,
        StDone = 3'd5,
        StErr  = 3'd6
    } load_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/im_loader_csum.sv
// XOR accumulator for the loader frame checksum; clear has priority over update.
module im_loader_csum (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       upd,
    input  logic [7:0] data,
    output logic       match
);

    logic [7:0] csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= 8'h00;
        end else if (clr) begin
            csum <= 8'h00;
        end else if (upd) begin
            csum <= csum ^ data;
        end
    end

    assign match = (data == csum);

endmodule

// File: rtl/im_loader.sv
// Byte-stream program loader: assembles 9-bit instructions from a framed byte
// stream, writes them to instruction memory and holds the CPU until a frame checks out.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned INSTR_W   = 9,
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    input  logic               rearm,
    output logic               im_we,
    output logic [ADDR_W-1:0]  im_addr,
    output logic [INSTR_W-1:0] im_wdata,
    output logic               cpu_hold,
    output logic               load_done,
    output logic               load_err
);

    // Count must hold a full frame of 2^ADDR_W words.
    localparam int unsigned CNT_W   = ADDR_W + 1;
    localparam int unsigned MAX_LEN = 1 << ADDR_W;

    load_state_t       state;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        lo;

    logic xfer;
    logic is_sync;
    logic len_bad;
    logic csum_clr;
    logic csum_upd;
    logic csum_match;

    assign in_ready = (state != StDone);
    assign xfer     = in_valid & in_ready;
    assign is_sync  = (in_data == SYNC_BYTE);
    assign len_bad  = (in_data == 8'h00) || (32'(in_data) > MAX_LEN);

    always_comb begin
        csum_clr = 1'b0;
        csum_upd = 1'b0;
        if (xfer) begin
            csum_clr = ((state == StSync) || (state == StErr)) && is_sync;
            csum_upd = (state == StLen) || (state == StLo) || (state == StHi);
        end
    end

    im_loader_csum u_csum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (csum_clr),
        .upd   (csum_upd),
        .data  (in_data),
        .match (csum_match)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StSync;
            count     <= '0;
            addr      <= '0;
            lo        <= 8'h00;
            im_we     <= 1'b0;
            im_addr   <= '0;
            im_wdata  <= '0;
            cpu_hold  <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            im_we <= 1'b0;
            unique case (state)
                StSync: begin
                    if (xfer && is_sync) begin
                        state    <= StLen;
                        load_err <= 1'b0;
                    end
                end
                StLen: begin
                    if (xfer) begin
                        if (len_bad) begin
                            state    <= StErr;
                            load_err <= 1'b1;
                        end else begin
                            count <= CNT_W'(in_data);
                            addr  <= '0;
                            state <= StLo;
                        end
                    end
                end
                StLo: begin
                    if (xfer) begin
                        lo    <= in_data;
                        state <= StHi;
                    end
                end
                StHi: begin
                    if (xfer) begin
                        if (in_data[7:1] != 7'd0) begin
                            state    <= StErr;
                            load_err <= 1'b1;
                        end else begin
                            im_we    <= 1'b1;
                            im_addr  <= addr;
                            im_wdata <= INSTR_W'({in_data[0], lo});
                            addr     <= addr + ADDR_W'(1);
                            count    <= count - CNT_W'(1);
                            state    <= (count == CNT_W'(1)) ? StCsum : StLo;
                        end
                    end
                end
                StCsum: begin
                    if (xfer) begin
                        if (csum_match) begin
                            state     <= StDone;
                            cpu_hold  <= 1'b0;
                            load_done <= 1'b1;
                        end else begin
                            state    <= StErr;
                            load_err <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (rearm) begin
                        state     <= StSync;
                        cpu_hold  <= 1'b1;
                        load_done <= 1'b0;
                    end
                end
                StErr: begin
                    if (xfer && is_sync) begin
                        state    <= StLen;
                        load_err <= 1'b0;
                    end
                end
                default: begin
                    state <= StSync;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: table of whole frames plus hand-written
// sequences for full depth, rearm, async reset and gapped input.
module tb_im_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       rearm = 1'b0;
    logic       im_we;
    logic [3:0] im_addr;
    logic [8:0] im_wdata;
    logic       cpu_hold;
    logic       load_done;
    logic       load_err;

    int checks = 0;
    int failures = 0;

    logic [3:0] wr_a[$];
    logic [8:0] wr_d[$];

    im_loader #(
        .ADDR_W    (4),
        .INSTR_W   (9),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .rearm     (rearm),
        .im_we     (im_we),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            wr_a.push_back(im_addr);
            wr_d.push_back(im_wdata);
        end
    end

    typedef struct packed {
        logic [0:7][7:0] bytes;
        logic [3:0]      nbytes;
        logic [1:0]      nwr;
        logic [3:0]      a0;
        logic [8:0]      d0;
        logic [3:0]      a1;
        logic [8:0]      d1;
        logic            done;
        logic            err;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=%0b required=1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rearm    = 1'b0;
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        wr_a.delete();
        wr_d.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " in_ready"}, 32'(in_ready), 1);
        chk({tag, " im_we"}, 32'(im_we), 0);
        chk({tag, " im_addr"}, 32'(im_addr), 0);
        chk({tag, " im_wdata"}, 32'(im_wdata), 0);
        chk({tag, " cpu_hold"}, 32'(cpu_hold), 1);
        chk({tag, " load_done"}, 32'(load_done), 0);
        chk({tag, " load_err"}, 32'(load_err), 0);
    endtask

    initial begin
        logic [7:0] csum;
        logic [7:0] lo_b;

        vecs[0] = '{bytes: {8'hA5, 8'h02, 8'h01, 8'h01, 8'hF0, 8'h00, 8'hF2, 8'h00}, nbytes: 7,
                    nwr: 2, a0: 0, d0: 9'h101, a1: 1, d1: 9'h0F0, done: 1, err: 0};
        vecs[1] = '{bytes: {8'hA5, 8'h01, 8'h41, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00}, nbytes: 5,
                    nwr: 1, a0: 0, d0: 9'h141, a1: 0, d1: 0, done: 0, err: 1};
        vecs[2] = '{bytes: {8'hA5, 8'h01, 8'h10, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00}, nbytes: 4,
                    nwr: 0, a0: 0, d0: 0, a1: 0, d1: 0, done: 0, err: 1};
        vecs[3] = '{bytes: {8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, nbytes: 2,
                    nwr: 0, a0: 0, d0: 0, a1: 0, d1: 0, done: 0, err: 1};
        vecs[4] = '{bytes: {8'hA5, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, nbytes: 2,
                    nwr: 0, a0: 0, d0: 0, a1: 0, d1: 0, done: 0, err: 1};
        vecs[5] = '{bytes: {8'h33, 8'hA5, 8'h01, 8'h7F, 8'h00, 8'h7E, 8'h00, 8'h00}, nbytes: 6,
                    nwr: 1, a0: 0, d0: 9'h07F, a1: 0, d1: 0, done: 1, err: 0};

        do_reset();
        chk_reset_outputs("reset");

        for (int v = 0; v < NV; v++) begin
            do_reset();
            for (int i = 0; i < int'(vecs[v].nbytes); i++) send(vecs[v].bytes[i]);
            idle(3);
            chk($sformatf("v%0d nwr", v), 32'(wr_a.size()), 32'(vecs[v].nwr));
            if (vecs[v].nwr >= 1 && wr_a.size() >= 1) begin
                chk($sformatf("v%0d a0", v), 32'(wr_a[0]), 32'(vecs[v].a0));
                chk($sformatf("v%0d d0", v), 32'(wr_d[0]), 32'(vecs[v].d0));
            end
            if (vecs[v].nwr >= 2 && wr_a.size() >= 2) begin
                chk($sformatf("v%0d a1", v), 32'(wr_a[1]), 32'(vecs[v].a1));
                chk($sformatf("v%0d d1", v), 32'(wr_d[1]), 32'(vecs[v].d1));
            end
            chk($sformatf("v%0d load_done", v), 32'(load_done), 32'(vecs[v].done));
            chk($sformatf("v%0d load_err", v), 32'(load_err), 32'(vecs[v].err));
            chk($sformatf("v%0d cpu_hold", v), 32'(cpu_hold), 32'(!vecs[v].done));
            chk($sformatf("v%0d in_ready", v), 32'(in_ready), 32'(!vecs[v].done));
            if (v == 1) begin
                send(8'hA5);
                chk("err_clear load_err", 32'(load_err), 0);
                chk("err_clear cpu_hold", 32'(cpu_hold), 1);
            end
        end

        // Full-depth frame of 16 words, write latency, DONE hold, rearm and overwrite.
        do_reset();
        send(8'hA5);
        send(8'h10);
        csum = 8'h10;
        for (int i = 0; i < 16; i++) begin
            lo_b = 8'(i * 3 + 1);
            send(lo_b);
            send({7'd0, 1'(i & 1)});
            csum = csum ^ lo_b ^ {7'd0, 1'(i & 1)};
            if (i == 0) begin
                chk("latency im_we", 32'(im_we), 1);
                chk("latency im_addr", 32'(im_addr), 0);
            end
        end
        chk("full no_done_before_csum", 32'(load_done), 0);
        send(csum);
        idle(1);
        chk("full nwr", 32'(wr_a.size()), 16);
        for (int i = 0; i < 16 && i < wr_a.size(); i++) begin
            chk($sformatf("full a%0d", i), 32'(wr_a[i]), 32'(i));
            chk($sformatf("full d%0d", i), 32'(wr_d[i]), 32'({1'(i & 1), 8'(i * 3 + 1)}));
        end
        chk("full load_done", 32'(load_done), 1);
        chk("full cpu_hold", 32'(cpu_hold), 0);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        idle(3);
        in_valid = 1'b0;
        chk("done_hold load_done", 32'(load_done), 1);
        chk("done_hold in_ready", 32'(in_ready), 0);
        chk("done_hold nwr", 32'(wr_a.size()), 16);
        rearm = 1'b1;
        chk("rearm pre cpu_hold", 32'(cpu_hold), 0);
        @(posedge clk);
        #1;
        rearm = 1'b0;
        chk("rearm cpu_hold", 32'(cpu_hold), 1);
        chk("rearm load_done", 32'(load_done), 0);
        chk("rearm in_ready", 32'(in_ready), 1);
        wr_a.delete();
        wr_d.delete();
        send(8'hA5);
        send(8'h01);
        send(8'h55);
        send(8'h01);
        send(8'h55);
        idle(1);
        chk("reload nwr", 32'(wr_a.size()), 1);
        if (wr_a.size() >= 1) begin
            chk("reload a0", 32'(wr_a[0]), 0);
            chk("reload d0", 32'(wr_d[0]), 9'h155);
        end
        chk("reload load_done", 32'(load_done), 1);

        // Asynchronous reset in the middle of a frame, then a gapped frame.
        do_reset();
        send(8'hA5);
        send(8'h02);
        send(8'h07);
        send(8'h01);
        send(8'h08);
        chk("mid im_wdata", 32'(im_wdata), 9'h107);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        wr_a.delete();
        wr_d.delete();
        send(8'hA5);
        idle(2);
        send(8'h01);
        rearm = 1'b1;
        idle(2);
        rearm = 1'b0;
        chk("gap no_write", 32'(wr_a.size()), 0);
        send(8'h22);
        idle(3);
        send(8'h00);
        idle(2);
        send(8'h23);
        idle(1);
        chk("gap nwr", 32'(wr_a.size()), 1);
        if (wr_a.size() >= 1) begin
            chk("gap a0", 32'(wr_a[0]), 0);
            chk("gap d0", 32'(wr_d[0]), 9'h022);
        end
        chk("gap load_done", 32'(load_done), 1);
        chk("gap load_err", 32'(load_err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
